// File: rtl/ucsbece154b_branch_predictor_if.sv
// Fetch/Execute bundle between the datapath (master) and the branch predictor (slave).
// Fetch: PCF_i in; BranchTakenF_o, BTBTargetF_o, PHTIndexF_o out. Execute: resolution inputs.
interface ucsbece154b_branch_predictor_if #(
    parameter int NUM_GHR_BITS = 5
);
    logic [31:0]             PCF_i;
    logic                    BranchTakenF_o;
    logic [31:0]             BTBTargetF_o;
    logic [NUM_GHR_BITS-1:0] PHTIndexF_o;
    logic [31:0]             PCE_i;
    logic [NUM_GHR_BITS-1:0] PHTIndexE_i;
    logic                    BranchE_i;
    logic                    JumpE_i;
    logic                    BranchTakenE_i;
    logic [31:0]             BranchTargetE_i;

    modport master (
        output PCF_i,
        input  BranchTakenF_o,
        input  BTBTargetF_o,
        input  PHTIndexF_o,
        output PCE_i,
        output PHTIndexE_i,
        output BranchE_i,
        output JumpE_i,
        output BranchTakenE_i,
        output BranchTargetE_i
    );

    modport slave (
        input  PCF_i,
        output BranchTakenF_o,
        output BTBTargetF_o,
        output PHTIndexF_o,
        input  PCE_i,
        input  PHTIndexE_i,
        input  BranchE_i,
        input  JumpE_i,
        input  BranchTakenE_i,
        input  BranchTargetE_i
    );
endinterface

// File: rtl/ucsbece154b_branch_predictor.sv
// Direct-mapped BTB plus 2-bit PHT predictor; bimodal indexing, gshare when BP_GSHARE_EN is defined.
// Ports: clk, reset (async active-low), bp (slave modport: fetch lookup + execute update).
module ucsbece154b_branch_predictor #(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5
) (
    input  logic clk,
    input  logic reset,
    ucsbece154b_branch_predictor_if.slave bp
);

    localparam int IDX_W = $clog2(NUM_BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam int PHT_N = 1 << NUM_GHR_BITS;

    logic             btb_valid_q [NUM_BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag_q   [NUM_BTB_ENTRIES];
    logic [31:0]      btb_tgt_q   [NUM_BTB_ENTRIES];
    logic             btb_jmp_q   [NUM_BTB_ENTRIES];
    logic             btb_br_q    [NUM_BTB_ENTRIES];
    logic [1:0]       pht_q       [PHT_N];

    logic [NUM_GHR_BITS-1:0] ghr_q, ghr_d;
    logic [1:0]              pht_d;

    // Word-offset bits never participate in indexing or tags.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.PCF_i[1:0], bp.PCE_i[1:0]};

    // ---------------- Fetch lookup (reads current state only) ----------------
    logic [IDX_W-1:0]        f_idx;
    logic [TAG_W-1:0]        f_tag;
    logic                    f_hit;
    logic [NUM_GHR_BITS-1:0] f_pht_idx;

    assign f_idx = bp.PCF_i[IDX_W+1:2];
    assign f_tag = bp.PCF_i[31:IDX_W+2];
    assign f_hit = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag);

`ifdef BP_GSHARE_EN
    assign f_pht_idx = bp.PCF_i[NUM_GHR_BITS+1:2] ^ ghr_q;
`else
    assign f_pht_idx = bp.PCF_i[NUM_GHR_BITS+1:2];
`endif

    assign bp.PHTIndexF_o    = f_pht_idx;
    assign bp.BranchTakenF_o = f_hit &&
                               (btb_jmp_q[f_idx] ||
                                (btb_br_q[f_idx] && pht_q[f_pht_idx][1]));
    assign bp.BTBTargetF_o   = f_hit ? btb_tgt_q[f_idx] : 32'h0;

    // ---------------- Execute update ----------------
    logic [IDX_W-1:0] e_idx;
    logic [TAG_W-1:0] e_tag;
    logic [1:0]       e_cnt;
    logic             btb_we;

    assign e_idx  = bp.PCE_i[IDX_W+1:2];
    assign e_tag  = bp.PCE_i[31:IDX_W+2];
    assign e_cnt  = pht_q[bp.PHTIndexE_i];
    // Only redirecting control flow earns a BTB slot.
    assign btb_we = bp.JumpE_i || (bp.BranchE_i && bp.BranchTakenE_i);

    always_comb begin
        pht_d = e_cnt;
        if (bp.BranchTakenE_i) begin
            if (e_cnt != 2'b11) pht_d = e_cnt + 2'd1;
        end else begin
            if (e_cnt != 2'b00) pht_d = e_cnt - 2'd1;
        end
    end

    always_comb begin
        ghr_d = ghr_q;
        if (bp.BranchE_i)
            ghr_d = {ghr_q[NUM_GHR_BITS-2:0], bp.BranchTakenE_i};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q <= '0;
            for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
                btb_valid_q[i] <= 1'b0;
                btb_tag_q[i]   <= '0;
                btb_tgt_q[i]   <= '0;
                btb_jmp_q[i]   <= 1'b0;
                btb_br_q[i]    <= 1'b0;
            end
            for (int j = 0; j < PHT_N; j++)
                pht_q[j] <= 2'b01;
        end else begin
            ghr_q <= ghr_d;
            if (bp.BranchE_i)
                pht_q[bp.PHTIndexE_i] <= pht_d;
            if (btb_we) begin
                btb_valid_q[e_idx] <= 1'b1;
                btb_tag_q[e_idx]   <= e_tag;
                btb_tgt_q[e_idx]   <= bp.BranchTargetE_i;
                btb_jmp_q[e_idx]   <= bp.JumpE_i;
                btb_br_q[e_idx]    <= bp.BranchE_i;
            end
        end
    end

endmodule

// File: tb/tb_ucsbece154b_branch_predictor.sv
// Directed scoreboard bench for ucsbece154b_branch_predictor.
// Lookups push expectations; checks pop and compare after the lookup settles.
module tb_ucsbece154b_branch_predictor;

    localparam int G = 5;
`ifdef BP_GSHARE_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif

    logic clk;
    logic reset;

    ucsbece154b_branch_predictor_if #(.NUM_GHR_BITS(G)) bpif ();

    ucsbece154b_branch_predictor #(
        .NUM_BTB_ENTRIES(32),
        .NUM_GHR_BITS(G)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bpif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         tk;
        logic [31:0]  tg;
        logic [G-1:0] idx;
    } exp_t;

    exp_t   exp_q[$];
    string  name_q[$];
    int     checks = 0;
    int     errors = 0;
    logic [G-1:0] ghr_m = '0;

    function automatic logic [G-1:0] idx_of(input logic [31:0] pc);
        logic [G-1:0] b;
        b = pc[G+1:2];
        return GSHARE ? (b ^ ghr_m) : b;
    endfunction

    task automatic push(input string nm, input logic tk,
                        input logic [31:0] tg, input logic [G-1:0] idx);
        exp_t e;
        e.tk  = tk;
        e.tg  = tg;
        e.idx = idx;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic check();
        exp_t  e;
        exp_t  o;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        o.tk  = bpif.BranchTakenF_o;
        o.tg  = bpif.BTBTargetF_o;
        o.idx = bpif.PHTIndexF_o;
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: got tk=%0b tgt=%h idx=%h, expected tk=%0b tgt=%h idx=%h",
                   nm, o.tk, o.tg, o.idx, e.tk, e.tg, e.idx);
        end
    endtask

    task automatic lookup(input string nm, input logic [31:0] pc,
                          input logic tk, input logic [31:0] tg);
        @(negedge clk);
        bpif.PCF_i = pc;
        push(nm, tk, tg, idx_of(pc));
        #1;
        check();
    endtask

    task automatic clear_e();
        bpif.BranchE_i      = 1'b0;
        bpif.JumpE_i        = 1'b0;
        bpif.BranchTakenE_i = 1'b0;
    endtask

    task automatic set_e(input logic [31:0] pc, input logic br, input logic jmp,
                         input logic tk, input logic [31:0] tg);
        bpif.PCE_i           = pc;
        bpif.PHTIndexE_i     = idx_of(pc);
        bpif.BranchE_i       = br;
        bpif.JumpE_i         = jmp;
        bpif.BranchTakenE_i  = tk;
        bpif.BranchTargetE_i = tg;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic br, input logic jmp,
                           input logic tk, input logic [31:0] tg);
        @(negedge clk);
        set_e(pc, br, jmp, tk, tg);
        @(posedge clk);
        #1;
        clear_e();
        if (br) ghr_m = {ghr_m[G-2:0], tk};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        bpif.PCF_i = 32'h100;
        bpif.PCE_i = 32'h0;
        bpif.PHTIndexE_i = '0;
        bpif.BranchTargetE_i = 32'h0;
        clear_e();

        lookup("in_reset", 32'h100, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        lookup("post_reset", 32'h100, 1'b0, 32'h0);

        // Same-cycle write and read of one entry sees the old value.
        @(negedge clk);
        set_e(32'h100, 1'b0, 1'b1, 1'b0, 32'h200);
        bpif.PCF_i = 32'h100;
        push("write_read_old", 1'b0, 32'h0, idx_of(32'h100));
        #1;
        check();
        @(posedge clk);
        #1;
        clear_e();
        lookup("jal_hit", 32'h100, 1'b1, 32'h200);

        // Branch at 0x40: counter 01 -> 10 -> 11 -> 11 (saturate high).
        resolve(32'h40, 1'b1, 1'b0, 1'b1, 32'h80);
        lookup("br_t1", 32'h40, 1'b1, 32'h80);
        resolve(32'h40, 1'b1, 1'b0, 1'b1, 32'h80);
        lookup("br_t2", 32'h40, 1'b1, 32'h80);
        resolve(32'h40, 1'b1, 1'b0, 1'b1, 32'h80);
        lookup("br_sat_hi", 32'h40, 1'b1, 32'h80);

        // 11 -> 10 -> 01 -> 00 -> 00 (saturate low); BTB entry kept.
        resolve(32'h40, 1'b1, 1'b0, 1'b0, 32'h80);
        lookup("br_nt1", 32'h40, 1'b1, 32'h80);
        resolve(32'h40, 1'b1, 1'b0, 1'b0, 32'h80);
        lookup("br_nt2", 32'h40, 1'b0, 32'h80);
        resolve(32'h40, 1'b1, 1'b0, 1'b0, 32'h80);
        lookup("br_nt3", 32'h40, 1'b0, 32'h80);
        resolve(32'h40, 1'b1, 1'b0, 1'b0, 32'h80);
        lookup("br_sat_lo", 32'h40, 1'b0, 32'h80);
        resolve(32'h40, 1'b1, 1'b0, 1'b1, 32'h80);
        lookup("br_rec1", 32'h40, 1'b0, 32'h80);
        resolve(32'h40, 1'b1, 1'b0, 1'b1, 32'h80);
        lookup("br_rec2", 32'h40, 1'b1, 32'h80);

        // Not-taken branch must neither allocate nor overwrite.
        resolve(32'h300, 1'b1, 1'b0, 1'b0, 32'h500);
        lookup("nt_no_alloc", 32'h300, 1'b0, 32'h0);
        lookup("nt_no_modify", 32'h100, 1'b1, 32'h200);

        // Tag mismatch on a shared index, then direct-mapped overwrite.
        lookup("tag_miss", 32'h180, 1'b0, 32'h0);
        resolve(32'h180, 1'b0, 1'b1, 1'b0, 32'h400);
        lookup("overwrite_hit", 32'h180, 1'b1, 32'h400);
        lookup("overwrite_evict", 32'h100, 1'b0, 32'h0);

        lookup("idx_mid", 32'h44, 1'b0, 32'h0);
        lookup("idx_max", 32'h7C, 1'b0, 32'h0);

        // Reset asserted over a pending jal write discards it.
        @(negedge clk);
        set_e(32'h100, 1'b0, 1'b1, 1'b0, 32'h200);
        reset = 1'b0;
        ghr_m = '0;
        @(posedge clk);
        @(negedge clk);
        clear_e();
        reset = 1'b1;
        lookup("rst_discard", 32'h100, 1'b0, 32'h0);
        lookup("rst_btb_clear", 32'h40, 1'b0, 32'h0);

        // T, T, NT from a cleared GHR leaves GHR = 00110.
        resolve(32'h40, 1'b1, 1'b0, 1'b1, 32'h80);
        resolve(32'h40, 1'b1, 1'b0, 1'b1, 32'h80);
        resolve(32'h40, 1'b1, 1'b0, 1'b0, 32'h80);
        @(negedge clk);
        bpif.PCF_i = 32'h40;
        push("ghr_index", GSHARE ? 1'b0 : 1'b1, 32'h80,
             GSHARE ? 5'h16 : 5'h10);
        #1;
        check();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
